regfile_req_responder: RTL and testbench

- Responder-side wrapper around 32x32 register storage.
- Accepts write requests and dual-port read requests over valid/ready handshakes, and returns read data on a buffered response channel with backpressure.
- After every reset it sequences a hardware clear of all entries.
- Sits between the decode/writeback stages and the register storage; register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_req_responder_if.sv | 43 ++++
 rtl/regfile_rsp_fifo.sv | 64 ++++++
 rtl/regfile_req_responder.sv | 118 +++++++++++
 tb/tb_regfile_req_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file responder.
//   REG_ADDR_W / REG_DATA_W / REG_COUNT : storage geometry
//   reg_addr_t / reg_data_t             : index and data types
//   rf_state_t                          : responder FSM state
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_req_responder_if.sv
// Request/response bundle between the decode/writeback stages and the
// register-file responder.
//   write request : wr_valid, wr_ready, wr_addr, wr_data
//   read request  : rd_valid, rd_ready, rd_addr_a, rd_addr_b
//   read response : rsp_valid, rsp_ready, rsp_data_a, rsp_data_b
// Modports: slave (responder side), master (requester side).
interface regfile_req_responder_if import regfile_pkg::*; #(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr_a, rd_addr_b,
        input  rsp_ready,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data_a, rsp_data_b
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr_a, rd_addr_b,
        output rsp_ready,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data_a, rsp_data_b
    );

endinterface

// File: rtl/regfile_rsp_fifo.sv
// Response buffer: DEPTH-entry circular FIFO of packed {port A, port B} data.
//   clock, ctrl_reset : clock and synchronous active-high flush
//   push, push_data   : enqueue (ignored when full)
//   pop               : dequeue (ignored when empty)
//   head_data         : oldest entry, held while not popped
//   count, empty      : occupancy
module regfile_rsp_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = entries[rd_ptr];

    // Entries are cleared on reset so the response data reads as zero
    // until the first push.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_req_responder.sv
// Responder wrapper around the register storage. After every reset it
// clears all entries one per cycle, then serves writes and dual-port reads;
// read data returns in order through a buffered response channel.
//   clock, ctrl_reset : clock and synchronous active-high reset
//   bus               : write / read / response handshakes (slave side)
//   busy              : high while the clear sequence runs
// Build option REGFILE_BYPASS_EN: a read accepted in the same cycle as a
// write to the same nonzero index returns the new write data.
//
// state    | meaning
// RF_CLEAR | zeroing entry clr_idx each cycle, no requests accepted
// RF_RUN   | accepting writes, and reads while the buffer has room
module regfile_req_responder import regfile_pkg::*; #(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    regfile_req_responder_if.slave  bus,
    output logic                    busy
);

    localparam int ENTRIES   = 1 << ADDR_W;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    rf_state_t             state;
    rf_state_t             state_next;
    logic [ADDR_W-1:0]     clr_idx;
    logic [ADDR_W-1:0]     clr_idx_next;
    logic                  wr_en;
    logic                  rd_en;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_W-1:0]     rd_a;
    logic [DATA_W-1:0]     rd_b;
    logic [DATA_W-1:0]     mem [ENTRIES];
    logic [RSP_CNT_W-1:0]  rsp_count;
    logic                  rsp_empty;
    logic [2*DATA_W-1:0]   rsp_head;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // rd_ready looks only at the registered count; a pop in the same cycle
    // does not free a slot until the next cycle.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        busy         = 1'b1;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        unique case (state)
            RF_CLEAR: begin
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == '1) state_next = RF_RUN;
            end
            RF_RUN: begin
                busy  = 1'b0;
                wr_en = 1'b1;
                rd_en = (rsp_count < RSP_CNT_W'(RSP_DEPTH));
            end
        endcase
    end

    assign bus.wr_ready = wr_en;
    assign bus.rd_ready = rd_en;
    assign wr_fire      = bus.wr_valid & wr_en;
    assign rd_fire      = bus.rd_valid & rd_en;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            if (state == RF_CLEAR)
                mem[clr_idx] <= '0;
            else if (wr_fire && (bus.wr_addr != '0))
                mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_a = (bus.rd_addr_a == '0) ? '0 : mem[bus.rd_addr_a];
        rd_b = (bus.rd_addr_b == '0) ? '0 : mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr_a))
            rd_a = bus.wr_data;
        if (wr_fire && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr_b))
            rd_b = bus.wr_data;
`else
        // Without forwarding a same-cycle write is seen by later reads only.
`endif
    end

    regfile_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_rsp_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (rd_fire),
        .push_data  ({rd_a, rd_b}),
        .pop        (bus.rsp_ready),
        .head_data  (rsp_head),
        .count      (rsp_count),
        .empty      (rsp_empty)
    );

    assign bus.rsp_valid  = ~rsp_empty;
    assign bus.rsp_data_a = rsp_head[2*DATA_W-1:DATA_W];
    assign bus.rsp_data_b = rsp_head[DATA_W-1:0];

endmodule

// File: tb/tb_regfile_req_responder.sv
module tb_regfile_req_responder;
    import regfile_pkg::*;

    localparam int DEPTH = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    logic busy;

    always #5 clock = ~clock;

    regfile_req_responder_if #(.ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

    regfile_req_responder #(
        .ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W), .RSP_DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus),
        .busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [32];
    logic [63:0] m_q [$];
    int          m_clr_left = 0;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] rd_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && bus.wr_valid && bus.wr_addr == a) return bus.wr_data;
        return m_mem[a];
    endfunction

    always @(posedge clock) begin : model_p
        logic [31:0] va, vb;
        bit rd_acc;
        if (ctrl_reset) begin
            m_q.delete();
            m_clr_left = 32;
            foreach (m_mem[i]) m_mem[i] = 32'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_clr_left > 0) begin
                m_clr_left--;
            end else begin
                rd_acc = bus.rd_valid && (m_q.size() < DEPTH);
                va = rd_val(bus.rd_addr_a);
                vb = rd_val(bus.rd_addr_b);
                if (bus.rsp_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (rd_acc) m_q.push_back({va, vb});
                if (bus.wr_valid && bus.wr_addr != 5'd0) m_mem[bus.wr_addr] = bus.wr_data;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid && !ctrl_reset) begin
            check("busy", 64'(busy), 64'(m_clr_left > 0));
            check("wr_ready", 64'(bus.wr_ready), 64'(m_clr_left == 0));
            check("rd_ready", 64'(bus.rd_ready), 64'(m_clr_left == 0 && m_q.size() < DEPTH));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0)
                check("rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, m_q[0]);
        end
    end

    // ---------------- observed responses ----------------
    logic [63:0] got [$];
    always @(posedge clock) begin
        if (!ctrl_reset && bus.rsp_valid && bus.rsp_ready)
            got.push_back({bus.rsp_data_a, bus.rsp_data_b});
    end

    task automatic check_got(input string name, input int idx, input logic [63:0] exp);
        if (idx < got.size()) check(name, got[idx], exp);
        else begin
            checks++;
            failures++;
            $display("FAIL %s missing response idx=%0d required=%0h", name, idx, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        int n = 0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        while (!bus.rd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL rd_accept timeout actual=no_accept required=accept");
        end
        tick();
        bus.rd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain timeout actual=rsp_valid_stuck required=empty");
        end
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] v;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        bus.rsp_ready = 1'b1;

        // reset held for two edges
        ctrl_reset = 1'b1;
        tick();
        tick();
        ctrl_reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("reset_rd_ready", 64'(bus.rd_ready), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 64'd0);
        wait_not_busy(n);
        check("clear_cycles", 64'(n), 64'd32);

        // all entries cleared
        got.delete();
        for (int i = 0; i < 32; i++) do_read(5'(i), 5'(31 - i));
        drain();
        for (int i = 0; i < 32; i++) check_got("cleared_read", i, 64'd0);

        // write then read
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'h1000DEAD);
        got.delete();
        for (int i = 0; i < 32; i++) do_read(5'(i), 5'(i));
        drain();
        check_got("dead_idx0", 0, 64'd0);
        check_got("dead_idx1", 1, 64'h1000DEAD_1000DEAD);
        for (int i = 1; i < 32; i++) check_got("dead_read", i, 64'h1000DEAD_1000DEAD);

        // walking ones
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'd1 << i);
        got.delete();
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(i));
            check("walk_rsp_latency", 64'(bus.rsp_valid), 64'd1);
        end
        drain();
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'd0 : (32'd1 << i);
            check_got("walk_read", i, {v, v});
        end
        check_got("walk_idx31", 31, 64'h80000000_80000000);

        // backpressure
        do_write(5'd3, 32'd3);
        do_write(5'd4, 32'd4);
        do_write(5'd5, 32'd5);
        bus.rsp_ready = 1'b0;
        got.delete();
        do_read(5'd3, 5'd3);
        do_read(5'd4, 5'd4);
        bus.rd_valid = 1'b1;
        bus.rd_addr_a = 5'd5;
        bus.rd_addr_b = 5'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_rd_ready", 64'(bus.rd_ready), 64'd0);
            check("bp_rsp_data_a", 64'(bus.rsp_data_a), 64'd3);
            check("bp_rsp_data_b", 64'(bus.rsp_data_b), 64'd3);
        end
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.rd_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        bus.rd_valid = 1'b0;
        drain();
        check_got("bp_order0", 0, {32'd3, 32'd3});
        check_got("bp_order1", 1, {32'd4, 32'd4});
        check_got("bp_order2", 2, {32'd5, 32'd5});

        // same-cycle write/read hazard
        do_write(5'd7, 32'h11);
        got.delete();
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h22;
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd7;
        check("hazard_rd_ready", 64'(bus.rd_ready), 64'd1);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        do_read(5'd7, 5'd7);
        drain();
        v = BYP ? 32'h22 : 32'h11;
        check_got("hazard_same_cycle", 0, {v, v});
        check_got("hazard_next", 1, {32'h22, 32'h22});

        // reset mid-operation
        do_write(5'd9, 32'hABCD);
        bus.rsp_ready = 1'b0;
        do_read(5'd1, 5'd1);
        do_read(5'd2, 5'd2);
        check("mid_buffered_valid", 64'(bus.rsp_valid), 64'd1);
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd1);
        wait_not_busy(n);
        check("mid_clear_cycles", 64'(n), 64'd32);
        bus.rsp_ready = 1'b1;
        got.delete();
        do_read(5'd9, 5'd9);
        drain();
        check_got("mid_reg9_cleared", 0, 64'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
